// File: rtl/ldpc_frame_ctrl.sv
// Frame-level load/iterate/unload sequencer for the QC-LDPC min-sum decoder array.
// Optional early termination on an all-zero syndrome: define LDPC_EARLY_TERM_EN.
module ldpc_frame_ctrl #(
  parameter int unsigned data_w = 8,
  parameter int unsigned D      = 64,
  parameter int unsigned R      = 32,
  parameter int unsigned C      = 16,
  parameter int unsigned MAX_IT = 10,
  parameter int unsigned IT_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [data_w*D-1:0]      in_data,
  output logic [data_w*R*D-1:0]    arr_llr,
  output logic                     arr_init,
  output logic                     arr_step,
  input  logic                     arr_ack,
  input  logic [C*D-1:0]           arr_synd,
  input  logic [R*D-1:0]           arr_dec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [D-1:0]             out_data,
  output logic [IT_W-1:0]          out_iter,
  output logic                     out_conv,
  output logic                     busy
);

  localparam int unsigned BEAT_W = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned BLK_W  = data_w * D;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(R - 1);
  localparam logic [IT_W-1:0]   IT_MAX    = IT_W'(MAX_IT);

`ifdef LDPC_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_LOAD, S_INIT, S_STEP, S_WAIT, S_CHECK, S_UNLOAD
  } state_t;

  state_t              state;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [IT_W-1:0]     it_cnt;
  logic [BLK_W*R-1:0]  llr_buf;
  logic [R*D-1:0]      dec_buf;
  logic [C*D-1:0]      synd_r;

  logic conv_c;
  logic in_acc_c;
  logic out_acc_c;
  logic last_c;
  logic term_c;

  assign arr_llr   = llr_buf;
  assign conv_c    = ~|synd_r;
  assign in_acc_c  = in_valid && in_ready;
  assign out_acc_c = out_valid && out_ready;
  assign last_c    = (beat_cnt == LAST_BEAT);
  assign term_c    = (EARLY_TERM && conv_c) || (it_cnt == IT_MAX);

  // Frame buffers carry no reset; they are always written before being read.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && in_acc_c) begin
      llr_buf[32'(beat_cnt)*BLK_W +: BLK_W] <= in_data;
    end
    if (state == S_WAIT && arr_ack) begin
      synd_r  <= arr_synd;
      dec_buf <= arr_dec;
    end
  end

  // Sequencer; every output is registered and set on the transition into its state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_LOAD;
      beat_cnt  <= '0;
      it_cnt    <= '0;
      out_iter  <= '0;
      out_conv  <= 1'b0;
      out_data  <= '0;
      arr_init  <= 1'b0;
      arr_step  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      arr_init <= 1'b0;
      arr_step <= 1'b0;
      unique case (state)
        S_LOAD: begin
          if (in_acc_c) begin
            if (last_c) begin
              beat_cnt <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              arr_init <= 1'b1;
              state    <= S_INIT;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_INIT: begin
          it_cnt   <= '0;
          arr_step <= 1'b1;
          state    <= S_STEP;
        end
        S_STEP: begin
          it_cnt <= it_cnt + 1'b1;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (arr_ack) begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (term_c) begin
            out_iter  <= it_cnt;
            out_conv  <= conv_c;
            out_valid <= 1'b1;
            out_data  <= dec_buf[D-1:0];
            state     <= S_UNLOAD;
          end else begin
            arr_step <= 1'b1;
            state    <= S_STEP;
          end
        end
        S_UNLOAD: begin
          if (out_acc_c) begin
            if (last_c) begin
              beat_cnt  <= '0;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b1;
              state     <= S_LOAD;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              out_data <= dec_buf[(32'(beat_cnt) + 32'd1)*D +: D];
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

endmodule
